ram_clr_param: RTL

- Parametrised successor to the fixed 4K x 16 RAM.
- Generalises data width and address width, and adds a registered read with a valid flag.
- Adds a hardware clear sequencer that zeroes every word after reset or on request, with a ready flag that gates access.
- Sits in the memory subsystem as drop-in data memory for the CPU datapath, and as scratch RAM for peripherals.

---
 rtl/ram_pkg.sv | 20 ++
 rtl/ram_clr_param_if.sv | 43 ++++
 rtl/ram_core.sv | 43 ++++
 rtl/ram_clr_param.sv | 110 +++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared definitions for the parametrised clearable RAM family: default
// geometry, FSM state encoding and a depth helper used by the memory blocks.
package ram_pkg;

    // Default geometry, matching the original 4K x 16 data memory.
    localparam int RAM_DATA_W = 16;
    localparam int RAM_ADDR_W = 12;

    // Controller states: sweeping zeros through the array, or serving the user port.
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } ram_state_e;

    // Number of words addressable with an address of the given width.
    function automatic int ram_depth(input int addr_w);
        return 32'sd1 <<< addr_w;
    endfunction

endpackage : ram_pkg

// File: rtl/ram_clr_param_if.sv
// User-side bus of the clearable RAM: address/data/strobes toward the memory,
// registered read data with its valid strobe and the ready flag back.
interface ram_clr_param_if
    import ram_pkg::*;
#(
    parameter int DATA_W = RAM_DATA_W,
    parameter int ADDR_W = RAM_ADDR_W
);

    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data_in;
    logic              write_enable;
    logic              read_enable;
    logic              clear;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              ready;

    // Requester side (CPU datapath, peripheral, testbench).
    modport master (
        output address,
        output data_in,
        output write_enable,
        output read_enable,
        output clear,
        input  data_out,
        input  data_valid,
        input  ready
    );

    // Memory side.
    modport slave (
        input  address,
        input  data_in,
        input  write_enable,
        input  read_enable,
        input  clear,
        output data_out,
        output data_valid,
        output ready
    );

endinterface : ram_clr_param_if

// File: rtl/ram_core.sv
// Single-port synchronous RAM array with a registered, read-before-write
// read port. Array contents are never reset; only the read register is.
module ram_core
    import ram_pkg::*;
#(
    parameter int DATA_W = RAM_DATA_W,
    parameter int ADDR_W = RAM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = ram_depth(ADDR_W);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DATA_W-1:0] rdata_r;

    // Array write port; no reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
    end

    // Registered read: samples the old word, so a same-address write lands afterwards.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata_r <= '0;
        end else if (re) begin
            rdata_r <= mem_r[addr];
        end else begin
            rdata_r <= rdata_r;
        end
    end

    assign rdata = rdata_r;

endmodule : ram_core

// File: rtl/ram_clr_param.sv
// Parametrised data RAM with a hardware clear sweep. After reset or a clear
// request every word is zeroed one per cycle; user access is gated by ready.
module ram_clr_param
    import ram_pkg::*;
#(
    parameter int DATA_W = RAM_DATA_W,
    parameter int ADDR_W = RAM_ADDR_W
) (
    input  logic           clk,
    input  logic           rst,
    ram_clr_param_if.slave bus
);

    localparam int                DEPTH    = ram_depth(ADDR_W);
    // Sweep ends on the all-ones address rather than on pointer wrap-around.
    localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);

    ram_state_e        state_r;
    ram_state_e        state_nxt_s;
    logic [ADDR_W-1:0] clr_ptr_r;
    logic [ADDR_W-1:0] clr_ptr_nxt_s;
    logic              ready_r;
    logic              data_valid_r;
    logic              valid_nxt_s;

    logic              core_we_req_s;
    logic              core_re_req_s;
    logic              core_we_s;
    logic              core_re_s;
    logic [ADDR_W-1:0] core_addr_s;
    logic [DATA_W-1:0] core_wdata_s;
    logic [DATA_W-1:0] core_rdata_s;

    // State, pointer and status flags; reset forces a fresh sweep from word 0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r      <= ST_CLEAR;
            clr_ptr_r    <= '0;
            ready_r      <= 1'b0;
            data_valid_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            clr_ptr_r    <= clr_ptr_nxt_s;
            ready_r      <= (state_nxt_s == ST_READY);
            data_valid_r <= valid_nxt_s;
        end
    end

    // Next state and array port mux: the sweep owns the array in CLEAR, the user in READY.
    always_comb begin
        state_nxt_s   = state_r;
        clr_ptr_nxt_s = clr_ptr_r;
        valid_nxt_s   = 1'b0;
        core_we_req_s = 1'b0;
        core_re_req_s = 1'b0;
        core_addr_s   = bus.address;
        core_wdata_s  = bus.data_in;

        case (state_r)
            ST_CLEAR: begin
                core_addr_s   = clr_ptr_r;
                core_wdata_s  = '0;
                core_we_req_s = 1'b1;
                clr_ptr_nxt_s = clr_ptr_r + ADDR_W'(1);
                if (clr_ptr_r == PTR_LAST) begin
                    state_nxt_s = ST_READY;
                end else begin
                    state_nxt_s = ST_CLEAR;
                end
            end
            ST_READY: begin
                if (bus.clear) begin
                    // Clear wins over any access presented in the same cycle.
                    state_nxt_s   = ST_CLEAR;
                    clr_ptr_nxt_s = '0;
                end else begin
                    core_we_req_s = bus.write_enable;
                    core_re_req_s = bus.read_enable;
                    valid_nxt_s   = bus.read_enable;
                end
            end
            default: begin
                state_nxt_s   = ST_CLEAR;
                clr_ptr_nxt_s = '0;
            end
        endcase
    end

    // A reset edge must not disturb the array or the read register contents path.
    assign core_we_s = rst & core_we_req_s;
    assign core_re_s = rst & core_re_req_s;

    ram_core #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_core (
        .clk   (clk),
        .rst   (rst),
        .we    (core_we_s),
        .re    (core_re_s),
        .addr  (core_addr_s),
        .wdata (core_wdata_s),
        .rdata (core_rdata_s)
    );

    assign bus.data_out   = core_rdata_s;
    assign bus.data_valid = data_valid_r;
    assign bus.ready      = ready_r;

endmodule : ram_clr_param
